// File: rtl/id_stage_if.sv
// Bundle between the IF/ID register, the later pipeline stages and the decode stage.
// The slave side is the decode stage; the master side drives the IF/ID, EX, MEM and WB state.
interface id_stage_if #(
  parameter int CNT_W = 32
);
  logic             valid_in;
  logic [31:0]      pc_in;
  logic [31:0]      instr_in;
  logic             ex_valid;
  logic             ex_wb_wen;
  logic [4:0]       ex_regw_addr;
  logic             mem_valid;
  logic             mem_wb_wen;
  logic [4:0]       mem_regw_addr;
  logic             wb_wen;
  logic [4:0]       wb_regw_addr;
  logic [31:0]      wb_data;
  logic             stall;
  logic             valid_out;
  logic [31:0]      pc_out;
  logic [31:0]      instr_out;
  logic [31:0]      sign_ext_out;
  logic [31:0]      zero_ext_out;
  logic [31:0]      opa_out;
  logic [31:0]      opb_out;
  logic [31:0]      data_rt_out;
  logic [4:0]       regw_addr_out;
  logic             wb_wen_out;
  logic             mem_wen_out;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  valid_in, pc_in, instr_in,
    input  ex_valid, ex_wb_wen, ex_regw_addr,
    input  mem_valid, mem_wb_wen, mem_regw_addr,
    input  wb_wen, wb_regw_addr, wb_data,
    output stall, valid_out, pc_out, instr_out, sign_ext_out, zero_ext_out,
    output opa_out, opb_out, data_rt_out, regw_addr_out, wb_wen_out, mem_wen_out,
    output stall_cnt
  );

  modport master (
    output valid_in, pc_in, instr_in,
    output ex_valid, ex_wb_wen, ex_regw_addr,
    output mem_valid, mem_wb_wen, mem_regw_addr,
    output wb_wen, wb_regw_addr, wb_data,
    input  stall, valid_out, pc_out, instr_out, sign_ext_out, zero_ext_out,
    input  opa_out, opb_out, data_rt_out, regw_addr_out, wb_wen_out, mem_wen_out,
    input  stall_cnt
  );
endinterface

// File: rtl/id_stage.sv
// Instruction decode: register file with WB bypass, control decode, RAW hazard
// detection against EX/MEM producers with bubble injection, and a stall-cycle counter.
module id_stage #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic   clk,
  input  logic   rst,
  id_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;

  logic [31:0]      rf [NREG];
  logic [CNT_W-1:0] cnt;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic        use_rs;
  logic        use_rt;
  logic        dec_wb;
  logic        dec_mw;
  logic [4:0]  dest;
  logic [31:0] opb;
  logic        hazard;
  logic        issue;

  // A write arriving from WB this cycle is visible to the read immediately,
  // so WB producers never need to stall the front end.
  function automatic logic [31:0] rf_read(input logic [4:0] addr, input logic [31:0] stored,
                                          input logic byp_en, input logic [4:0] byp_addr,
                                          input logic [31:0] byp_data);
    if (addr == 5'd0)
      return 32'h0;
    if (byp_en && byp_addr == addr)
      return byp_data;
    return stored;
  endfunction

  function automatic logic src_hit(input logic used, input logic [4:0] addr,
                                   input logic ex_w, input logic [4:0] ex_a,
                                   input logic mem_w, input logic [4:0] mem_a);
    return used && addr != 5'd0 && ((ex_w && ex_a == addr) || (mem_w && mem_a == addr));
  endfunction

  assign op    = bus.instr_in[31:26];
  assign rs    = bus.instr_in[25:21];
  assign rt    = bus.instr_in[20:16];
  assign rd    = bus.instr_in[15:11];
  assign funct = bus.instr_in[5:0];
  assign imm   = bus.instr_in[15:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign zext  = {16'h0, imm};

  assign rs_data = rf_read(rs, rf[rs], bus.wb_wen && !rst, bus.wb_regw_addr, bus.wb_data);
  assign rt_data = rf_read(rt, rf[rt], bus.wb_wen && !rst, bus.wb_regw_addr, bus.wb_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else if (bus.wb_wen && bus.wb_regw_addr != 5'd0) begin
      rf[bus.wb_regw_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    dec_wb = 1'b0;
    dec_mw = 1'b0;
    dest   = 5'd0;
    opb    = sext;
    unique case (op)
      OP_RTYPE: begin
        opb = rt_data;
        if (bus.instr_in != 32'h0) begin
          dest   = rd;
          use_rt = 1'b1;
          use_rs = !(funct == FN_SLL || funct == FN_SRL);
          dec_wb = 1'b1;
        end
      end
      OP_ADDI, OP_SLTI, OP_LW: begin
        dest   = rt;
        use_rs = 1'b1;
        dec_wb = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        dest   = rt;
        use_rs = 1'b1;
        dec_wb = 1'b1;
        opb    = zext;
      end
      OP_LUI: begin
        dest   = rt;
        dec_wb = 1'b1;
        opb    = {imm, 16'h0};
      end
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        dec_mw = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        opb    = rt_data;
      end
      default: ;
    endcase
  end

  assign hazard = bus.valid_in && !rst &&
                  (src_hit(use_rs, rs, bus.ex_valid && bus.ex_wb_wen, bus.ex_regw_addr,
                           bus.mem_valid && bus.mem_wb_wen, bus.mem_regw_addr) ||
                   src_hit(use_rt, rt, bus.ex_valid && bus.ex_wb_wen, bus.ex_regw_addr,
                           bus.mem_valid && bus.mem_wb_wen, bus.mem_regw_addr));
  assign issue  = bus.valid_in && !rst && !hazard;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (hazard)
      cnt <= cnt + 1'b1;
  end

  assign bus.stall         = hazard;
  assign bus.valid_out     = issue;
  assign bus.wb_wen_out    = issue && dec_wb;
  assign bus.mem_wen_out   = issue && dec_mw;
  assign bus.pc_out        = bus.pc_in;
  assign bus.instr_out     = bus.instr_in;
  assign bus.sign_ext_out  = sext;
  assign bus.zero_ext_out  = zext;
  assign bus.opa_out       = rs_data;
  assign bus.opb_out       = opb;
  assign bus.data_rt_out   = rt_data;
  assign bus.regw_addr_out = dest;
  assign bus.stall_cnt     = cnt;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized decode/hazard traffic
// checked against an instruction-level reference model of the decode stage.
module tb_id_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  id_stage_if #(.CNT_W(32)) bus();
  id_stage #(.NREG(32), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  typedef struct {
    bit          rs_u;
    bit          rt_u;
    bit          wb;
    bit          mw;
    bit          opb_known;
    logic [4:0]  dest;
    logic [31:0] opb;
  } dec_t;

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] i_ins(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] m_rd(logic [4:0] a);
    if (a == 0) return 32'h0;
    if (!rst && bus.wb_wen && bus.wb_regw_addr == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  // Reference: what each instruction reads, writes and feeds to operand B.
  function automatic dec_t m_dec(logic [31:0] ins);
    dec_t d;
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic [31:0] imm_s = {{16{ins[15]}}, ins[15:0]};
    d = '{0, 0, 0, 0, 1, 5'd0, 32'h0};
    if (op == 0) begin
      d.opb = m_rd(ins[20:16]);
      if (ins != 0) begin
        d.wb = 1; d.dest = ins[15:11]; d.rt_u = 1;
        d.rs_u = !(fn == 6'h00 || fn == 6'h02);
      end
    end else if (op == 6'h08 || op == 6'h0A || op == 6'h23) begin
      d.wb = 1; d.dest = ins[20:16]; d.rs_u = 1; d.opb = imm_s;
    end else if (op == 6'h0C || op == 6'h0D) begin
      d.wb = 1; d.dest = ins[20:16]; d.rs_u = 1; d.opb = {16'h0, ins[15:0]};
    end else if (op == 6'h0F) begin
      d.wb = 1; d.dest = ins[20:16]; d.opb = {ins[15:0], 16'h0};
    end else if (op == 6'h2B) begin
      d.mw = 1; d.rs_u = 1; d.rt_u = 1; d.opb = imm_s;
    end else if (op == 6'h04 || op == 6'h05) begin
      d.rs_u = 1; d.rt_u = 1; d.opb = m_rd(ins[20:16]);
    end else begin
      d.opb_known = 0;
    end
    return d;
  endfunction

  function automatic bit m_pending(logic [4:0] a);
    if (a == 0) return 0;
    return (bus.ex_valid && bus.ex_wb_wen && bus.ex_regw_addr == a) ||
           (bus.mem_valid && bus.mem_wb_wen && bus.mem_regw_addr == a);
  endfunction

  function automatic bit m_hazard();
    dec_t d;
    if (rst || !bus.valid_in) return 0;
    d = m_dec(bus.instr_in);
    return (d.rs_u && m_pending(bus.instr_in[25:21])) || (d.rt_u && m_pending(bus.instr_in[20:16]));
  endfunction

  task automatic tick();
    bit s;
    s = m_hazard();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0;
    end else begin
      if (s) m_cnt = m_cnt + 1;
      if (bus.wb_wen && bus.wb_regw_addr != 0) m_regs[bus.wb_regw_addr] = bus.wb_data;
    end
    #1;
  endtask

  task automatic idle();
    bus.valid_in = 0; bus.pc_in = 32'h0; bus.instr_in = 32'h0;
    bus.ex_valid = 0; bus.ex_wb_wen = 0; bus.ex_regw_addr = 0;
    bus.mem_valid = 0; bus.mem_wb_wen = 0; bus.mem_regw_addr = 0;
    bus.wb_wen = 0; bus.wb_regw_addr = 0; bus.wb_data = 32'h0;
  endtask

  task automatic wb_write(int a, logic [31:0] v);
    bus.wb_wen = 1; bus.wb_regw_addr = a[4:0]; bus.wb_data = v;
    tick();
    bus.wb_wen = 0;
  endtask

  task automatic test_reset();
    idle();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 0;
    rst = 1;
    tick(); tick();
    bus.valid_in = 1; bus.instr_in = r_ins(2, 3, 4, 0, 32'h20);
    bus.ex_valid = 1; bus.ex_wb_wen = 1; bus.ex_regw_addr = 2;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.valid_out); end
    total++; if (bus.wb_wen_out !== 1'b0) begin bad++; $display("FAIL reset_wbwen got %b want 0", bus.wb_wen_out); end
    total++; if (bus.stall_cnt !== 32'h0) begin bad++; $display("FAIL reset_cnt got %0d want 0", bus.stall_cnt); end
    tick();
    idle();
    rst = 0;
    for (int r = 1; r < 32; r += 7) begin
      bus.valid_in = 1; bus.instr_in = r_ins(r, r + 1, 3, 0, 32'h20);
      #1;
      total++; if (bus.opa_out !== 32'h0) begin bad++; $display("FAIL reset_reg r%0d got %h want 0", r, bus.opa_out); end
    end
    idle();
  endtask

  task automatic test_bypass();
    wb_write(1, 32'h0000_0011);
    bus.wb_wen = 1; bus.wb_regw_addr = 5; bus.wb_data = 32'h1234;
    bus.valid_in = 1; bus.pc_in = 32'h400; bus.instr_in = r_ins(5, 0, 3, 0, 32'h20);
    #1;
    total++; if (bus.opa_out !== 32'h1234) begin bad++; $display("FAIL bypass_opa got %h want 00001234", bus.opa_out); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL bypass_stall got %b want 0", bus.stall); end
    total++; if (bus.regw_addr_out !== 5'd3) begin bad++; $display("FAIL bypass_dest got %0d want 3", bus.regw_addr_out); end
    total++; if (bus.wb_wen_out !== 1'b1) begin bad++; $display("FAIL bypass_wbwen got %b want 1", bus.wb_wen_out); end
    total++; if (bus.pc_out !== 32'h400) begin bad++; $display("FAIL bypass_pc got %h want 00000400", bus.pc_out); end
    tick();
    bus.wb_wen = 0;
    #1;
    total++; if (bus.opa_out !== 32'h1234) begin bad++; $display("FAIL stored_opa got %h want 00001234", bus.opa_out); end
    idle();
  endtask

  task automatic test_raw_stall();
    logic [31:0] c0;
    c0 = m_cnt;
    bus.valid_in = 1; bus.instr_in = r_ins(2, 1, 4, 0, 32'h22);
    bus.ex_valid = 1; bus.ex_wb_wen = 1; bus.ex_regw_addr = 2;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL raw_ex_stall got %b want 1", bus.stall); end
    total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL raw_ex_valid got %b want 0", bus.valid_out); end
    total++; if (bus.wb_wen_out !== 1'b0) begin bad++; $display("FAIL raw_ex_wbwen got %b want 0", bus.wb_wen_out); end
    tick();
    total++; if (bus.stall_cnt !== c0 + 1) begin bad++; $display("FAIL raw_cnt1 got %0d want %0d", bus.stall_cnt, c0 + 1); end
    bus.ex_valid = 0; bus.ex_wb_wen = 0; bus.ex_regw_addr = 0;
    bus.mem_valid = 1; bus.mem_wb_wen = 1; bus.mem_regw_addr = 2;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL raw_mem_stall got %b want 1", bus.stall); end
    tick();
    bus.mem_valid = 0; bus.mem_wb_wen = 0; bus.mem_regw_addr = 0;
    bus.wb_wen = 1; bus.wb_regw_addr = 2; bus.wb_data = 32'hCAFE_0002;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL raw_wb_stall got %b want 0", bus.stall); end
    total++; if (bus.opa_out !== 32'hCAFE_0002) begin bad++; $display("FAIL raw_wb_opa got %h want cafe0002", bus.opa_out); end
    total++; if (bus.valid_out !== 1'b1) begin bad++; $display("FAIL raw_wb_valid got %b want 1", bus.valid_out); end
    total++; if (bus.stall_cnt !== c0 + 2) begin bad++; $display("FAIL raw_cnt2 got %0d want %0d", bus.stall_cnt, c0 + 2); end
    tick();
    idle();
  endtask

  task automatic test_no_stall_cases();
    bus.valid_in = 1; bus.instr_in = r_ins(0, 1, 4, 0, 32'h20);
    bus.ex_valid = 1; bus.ex_wb_wen = 1; bus.ex_regw_addr = 0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nostall_r0 got %b want 0", bus.stall); end
    bus.instr_in = r_ins(2, 1, 4, 0, 32'h22);
    bus.ex_wb_wen = 0; bus.ex_regw_addr = 2;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nostall_nowen got %b want 0", bus.stall); end
    bus.ex_wb_wen = 1; bus.ex_valid = 0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nostall_exinv got %b want 0", bus.stall); end
    bus.ex_valid = 1; bus.valid_in = 0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL nostall_idinv got %b want 0", bus.stall); end
    total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL idinv_valid got %b want 0", bus.valid_out); end
    idle();
  endtask

  task automatic test_shift_lui();
    bus.valid_in = 1; bus.instr_in = r_ins(9, 2, 1, 4, 32'h00);
    bus.ex_valid = 1; bus.ex_wb_wen = 1; bus.ex_regw_addr = 9;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL sll_rs_stall got %b want 0", bus.stall); end
    total++; if (bus.regw_addr_out !== 5'd1) begin bad++; $display("FAIL sll_dest got %0d want 1", bus.regw_addr_out); end
    bus.ex_regw_addr = 2;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL sll_rt_stall got %b want 1", bus.stall); end
    bus.instr_in = i_ins(6'h0F, 9, 7, 32'h8001);
    bus.ex_regw_addr = 9;
    #1;
    total++; if (bus.opb_out !== 32'h8001_0000) begin bad++; $display("FAIL lui_opb got %h want 80010000", bus.opb_out); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lui_stall got %b want 0", bus.stall); end
    total++; if (bus.regw_addr_out !== 5'd7) begin bad++; $display("FAIL lui_dest got %0d want 7", bus.regw_addr_out); end
    idle();
  endtask

  task automatic test_store();
    wb_write(6, 32'hA5A5_0006);
    wb_write(8, 32'h0000_0100);
    bus.valid_in = 1; bus.instr_in = i_ins(6'h2B, 8, 6, 32'hFFFC);
    #1;
    total++; if (bus.sign_ext_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL sw_sext got %h want fffffffc", bus.sign_ext_out); end
    total++; if (bus.zero_ext_out !== 32'h0000_FFFC) begin bad++; $display("FAIL sw_zext got %h want 0000fffc", bus.zero_ext_out); end
    total++; if (bus.mem_wen_out !== 1'b1) begin bad++; $display("FAIL sw_memwen got %b want 1", bus.mem_wen_out); end
    total++; if (bus.wb_wen_out !== 1'b0) begin bad++; $display("FAIL sw_wbwen got %b want 0", bus.wb_wen_out); end
    total++; if (bus.data_rt_out !== 32'hA5A5_0006) begin bad++; $display("FAIL sw_rt got %h want a5a50006", bus.data_rt_out); end
    total++; if (bus.opa_out !== 32'h100) begin bad++; $display("FAIL sw_opa got %h want 00000100", bus.opa_out); end
    total++; if (bus.opb_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL sw_opb got %h want fffffffc", bus.opb_out); end
    bus.mem_valid = 1; bus.mem_wb_wen = 1; bus.mem_regw_addr = 6;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL sw_mem_stall got %b want 1", bus.stall); end
    total++; if (bus.mem_wen_out !== 1'b0) begin bad++; $display("FAIL sw_bubble got %b want 0", bus.mem_wen_out); end
    tick();
    idle();
  endtask

  task automatic test_random();
    int ops [14] = '{0, 0, 8, 10, 12, 13, 15, 35, 43, 4, 5, 2, 63, 1};
    int fns [5] = '{32'h00, 32'h02, 32'h20, 32'h22, 32'h2A};
    dec_t d;
    bit e_s, e_vo;
    for (int n = 0; n < 400; n++) begin
      int op = ops[$urandom_range(0, 13)];
      if (op == 0)
        bus.instr_in = r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 31), fns[$urandom_range(0, 4)]);
      else
        bus.instr_in = i_ins(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 19) == 0) bus.instr_in = 32'h0;
      bus.valid_in = ($urandom_range(0, 4) != 0);
      bus.pc_in = $urandom;
      bus.ex_valid = $urandom_range(0, 1); bus.ex_wb_wen = $urandom_range(0, 1);
      bus.ex_regw_addr = $urandom_range(0, 7);
      bus.mem_valid = $urandom_range(0, 1); bus.mem_wb_wen = $urandom_range(0, 1);
      bus.mem_regw_addr = $urandom_range(0, 7);
      bus.wb_wen = $urandom_range(0, 1); bus.wb_regw_addr = $urandom_range(0, 7);
      bus.wb_data = $urandom;
      #1;
      d = m_dec(bus.instr_in);
      e_s = m_hazard();
      e_vo = bus.valid_in && !e_s;
      total++; if (bus.stall !== e_s) begin bad++; $display("FAIL rnd_stall n=%0d got %b want %b", n, bus.stall, e_s); end
      total++; if (bus.valid_out !== e_vo) begin bad++; $display("FAIL rnd_valid n=%0d got %b want %b", n, bus.valid_out, e_vo); end
      total++; if (bus.wb_wen_out !== (e_vo && d.wb)) begin bad++; $display("FAIL rnd_wbwen n=%0d got %b want %b", n, bus.wb_wen_out, e_vo && d.wb); end
      total++; if (bus.mem_wen_out !== (e_vo && d.mw)) begin bad++; $display("FAIL rnd_memwen n=%0d got %b want %b", n, bus.mem_wen_out, e_vo && d.mw); end
      total++; if (bus.opa_out !== m_rd(bus.instr_in[25:21])) begin bad++; $display("FAIL rnd_opa n=%0d got %h want %h", n, bus.opa_out, m_rd(bus.instr_in[25:21])); end
      total++; if (bus.data_rt_out !== m_rd(bus.instr_in[20:16])) begin bad++; $display("FAIL rnd_rt n=%0d got %h want %h", n, bus.data_rt_out, m_rd(bus.instr_in[20:16])); end
      total++; if (bus.instr_out !== bus.instr_in || bus.pc_out !== bus.pc_in) begin bad++; $display("FAIL rnd_pass n=%0d got %h/%h want %h/%h", n, bus.pc_out, bus.instr_out, bus.pc_in, bus.instr_in); end
      if (d.wb) begin
        total++; if (bus.regw_addr_out !== d.dest) begin bad++; $display("FAIL rnd_dest n=%0d got %0d want %0d", n, bus.regw_addr_out, d.dest); end
      end
      if (d.opb_known) begin
        total++; if (bus.opb_out !== d.opb) begin bad++; $display("FAIL rnd_opb n=%0d got %h want %h", n, bus.opb_out, d.opb); end
      end
      tick();
      total++; if (bus.stall_cnt !== m_cnt) begin bad++; $display("FAIL rnd_cnt n=%0d got %0d want %0d", n, bus.stall_cnt, m_cnt); end
    end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    wb_write(6, 32'h6666_6666);
    bus.valid_in = 1; bus.instr_in = r_ins(6, 0, 3, 0, 32'h20);
    bus.ex_valid = 1; bus.ex_wb_wen = 1; bus.ex_regw_addr = 6;
    tick(); tick();
    rst = 1;
    bus.wb_wen = 1; bus.wb_regw_addr = 10; bus.wb_data = 32'hDEAD_BEEF;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall got %b want 0", bus.stall); end
    total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_valid got %b want 0", bus.valid_out); end
    tick();
    rst = 0;
    idle();
    total++; if (bus.stall_cnt !== 32'h0) begin bad++; $display("FAIL rstmid_cnt got %0d want 0", bus.stall_cnt); end
    bus.valid_in = 1; bus.instr_in = r_ins(6, 10, 3, 0, 32'h20);
    #1;
    total++; if (bus.opa_out !== 32'h0) begin bad++; $display("FAIL rstmid_r6 got %h want 0", bus.opa_out); end
    total++; if (bus.data_rt_out !== 32'h0) begin bad++; $display("FAIL rstmid_r10 got %h want 0", bus.data_rt_out); end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_raw_stall();
    test_no_stall_cases();
    test_shift_lui();
    test_store();
    test_random();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
